noc_mem_arbiter: RTL and testbench
==================================

# noc_mem_arbiter

Two-to-one NoC packet arbiter that shares the single memory NoC port of the chipset memory path (NoC2 requests in, NoC3 responses out) between two requesters: port 0 (ASIC/chipset traffic) and port 1 (boot/debug master). It sits in the `clk` domain immediately upstream of the bidirectional async FIFO. It interleaves requests at packet granularity with round-robin fairness. It steers responses back to the requester selected by the response header's destination chip ID.

## Interface
Parameters:
- `DATA_W`, 64, flit width; equals `NOC_DATA_WIDTH`.
- `P1_CHIPID`, 14'h2000, NoC3 header `dst_chipid` value that routes a response to port 1. All other values route to port 0.

Ports:
- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s0_req_val`, `s0_req_dat`, `s0_req_rdy`  in/in/out  1/DATA_W/1  port 0 NoC2 requests.
- `s1_req_val`, `s1_req_dat`, `s1_req_rdy`  in/in/out  1/DATA_W/1  port 1 NoC2 requests.
- `m_req_val`, `m_req_dat`, `m_req_rdy`  out/out/in  1/DATA_W/1  merged NoC2 requests toward memory.
- `m_rsp_val`, `m_rsp_dat`, `m_rsp_rdy`  in/in/out  1/DATA_W/1  NoC3 responses from memory.
- `s0_rsp_val`, `s0_rsp_dat`, `s0_rsp_rdy`  out/out/in  1/DATA_W/1  port 0 responses.
- `s1_rsp_val`, `s1_rsp_dat`, `s1_rsp_rdy`  out/out/in  1/DATA_W/1  port 1 responses.

## Operation
- Header flit fields: `dst_chipid`=[63:50], `length`=[29:22] (payload flits after the header, 0..255).
- A packet is 1+`length` flits. A transfer occurs on val&rdy.
- Request side FSM, states: R_IDLE, R_P0, R_P1. Registers: 8-bit `req_cnt`, 1-bit `prio` (port with priority; reset 0).
  - R_IDLE: grant goes to the valid port. If both ports are valid, grant goes to `prio`. The granted header passes combinationally to `m_req_*` in the same cycle.
  - On header handshake with `length`=0: stay in R_IDLE and set `prio`=~granted.
  - On header handshake with `length`>0: load `req_cnt`=`length` and enter R_Pn.
  - R_Pn: `m_req` mirrors port n. Each handshake decrements `req_cnt`. The handshake at `req_cnt`==1 returns to R_IDLE and sets `prio`=~n.
  - The non-granted port's `req_rdy` is held at 0.
- Response side FSM, states: S_IDLE, S_P0, S_P1. Register: 8-bit `rsp_cnt`.
  - S_IDLE: destination is port 1 if header `dst_chipid`==`P1_CHIPID`, else port 0. The header passes combinationally. `m_rsp_rdy` equals the destination's `rsp_rdy`.
  - Length handling is the same as the request side: `length`=0 stays idle; otherwise load `rsp_cnt` and lock onto the destination until the last flit.
  - The non-selected port's `rsp_val` is 0. All `rsp_dat` outputs may carry `m_rsp_dat` unconditionally.
- The two FSMs are independent. Request and response traffic may flow in the same cycle.
- No buffering. The block does not alter data.

## Timing
- Zero-cycle latency on both paths (combinational val/dat/rdy passthrough). The only registers are the FSM state, the counters and `prio`.
- No combinational path from any `*_rdy` input to any `*_val` output.
- While `rst_n`=0: every `*_val` and `*_rdy` output is forced to 0. States reset to IDLE, counters to 0, `prio` to 0.
- Reset during a packet: the partial packet is abandoned. After reset the next flit on any port is treated as a header; recovery is the senders' responsibility.
- Valid held with ready low: grant and routing stay fixed. In IDLE, a newly valid higher-priority port may take the grant only before the current header handshakes. The grant is evaluated every IDLE cycle.
- Simultaneous last request flit of P0 and new P1 header: the last flit completes this cycle. The P1 header is accepted no earlier than the next cycle.
- A `length`=255 packet occupies 256 handshakes. The 8-bit counter must not wrap.

## Test plan
- Single port: port 0 sends header `length`=2 plus 2 payload flits with `m_req_rdy`=1. Required: 3 flits on `m_req` in consecutive cycles, data identical, `s1_req_rdy`=0 throughout.
- Contention: both ports hold `length`=1 packets continuously from reset. Required: output order P0,P0,P1,P1,P0,P0,…, and no packet is ever interleaved.
- Backpressure: toggle `m_req_rdy` 1/0 every cycle during a `length`=3 packet from port 1. Required: 4 flits delivered in order and the grant never switches mid-packet.
- Response routing: inject headers with `dst_chipid`=14'h2000 `length`=0, then 14'h0000 `length`=2. Required: 1 flit on `s1_rsp`, then 3 flits on `s0_rsp`, with `s1_rsp_val`=0 during the latter.
- Response stall: `s0_rsp_rdy`=0 during a port-0 response. Required: `m_rsp_rdy`=0, `s1_rsp_val`=0, and no flit lost on release.
- Reset mid-packet: assert `rst_n`=0 after 2 of 5 request flits. Required: all val/rdy outputs are 0 immediately. After release, `prio`=0 and the next port-0 flit is forwarded as a header, with the count taken from its `length` field.

Source files
------------

// File: rtl/noc_mem_arbiter.sv
// Two-to-one NoC packet arbiter in front of the memory port: round-robin merge of
// NoC2 requests at packet granularity, chip-ID steered split of NoC3 responses.
module noc_mem_arbiter #(
  parameter int          DATA_W    = 64,
  parameter logic [13:0] P1_CHIPID = 14'h2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_req_val,
  input  logic [DATA_W-1:0] s0_req_dat,
  output logic              s0_req_rdy,
  input  logic              s1_req_val,
  input  logic [DATA_W-1:0] s1_req_dat,
  output logic              s1_req_rdy,
  output logic              m_req_val,
  output logic [DATA_W-1:0] m_req_dat,
  input  logic              m_req_rdy,
  input  logic              m_rsp_val,
  input  logic [DATA_W-1:0] m_rsp_dat,
  output logic              m_rsp_rdy,
  output logic              s0_rsp_val,
  output logic [DATA_W-1:0] s0_rsp_dat,
  input  logic              s0_rsp_rdy,
  output logic              s1_rsp_val,
  output logic [DATA_W-1:0] s1_rsp_dat,
  input  logic              s1_rsp_rdy
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {R_IDLE, R_P0, R_P1} req_st_e;
  typedef enum logic [1:0] {S_IDLE, S_P0, S_P1} rsp_st_e;

  logic [NUM_PORTS-1:0]             req_val, req_rdy, rsp_val, rsp_rdy;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_dat, rsp_dat;

  assign req_val    = {s1_req_val, s0_req_val};
  assign req_dat    = {s1_req_dat, s0_req_dat};
  assign rsp_rdy    = {s1_rsp_rdy, s0_rsp_rdy};
  assign s0_req_rdy = req_rdy[0];
  assign s1_req_rdy = req_rdy[1];
  assign s0_rsp_val = rsp_val[0];
  assign s1_rsp_val = rsp_val[1];
  assign s0_rsp_dat = rsp_dat[0];
  assign s1_rsp_dat = rsp_dat[1];

  // Response data is broadcast; only the valid is steered.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp_dat
    assign rsp_dat[i] = m_rsp_dat;
  end

  // ---------------- request merge ----------------
  req_st_e    req_st, req_st_nxt;
  logic [7:0] req_cnt, req_cnt_nxt;
  logic       prio, prio_nxt;
  logic       req_gnt, req_hs;
  logic [7:0] req_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_st  <= R_IDLE;
      req_cnt <= '0;
      prio    <= 1'b0;
    end else begin
      req_st  <= req_st_nxt;
      req_cnt <= req_cnt_nxt;
      prio    <= prio_nxt;
    end
  end

  assign req_hs  = m_req_val & m_req_rdy;
  assign req_len = m_req_dat[29:22];

  always_comb begin
    req_st_nxt  = req_st;
    req_cnt_nxt = req_cnt;
    prio_nxt    = prio;
    if (req_hs) begin
      if (req_st == R_IDLE) begin
        if (req_len == 8'd0) begin
          prio_nxt = ~req_gnt;
        end else begin
          req_cnt_nxt = req_len;
          req_st_nxt  = req_gnt ? R_P1 : R_P0;
        end
      end else begin
        // Counter stops at the last payload flit, so length 255 never wraps.
        req_cnt_nxt = req_cnt - 8'd1;
        if (req_cnt == 8'd1) begin
          req_st_nxt = R_IDLE;
          prio_nxt   = ~req_gnt;
        end
      end
    end
  end

  // Grant depends only on valids and state, keeping rdy out of every val path.
  always_comb begin
    req_gnt = 1'b0;
    unique case (req_st)
      R_P0:    req_gnt = 1'b0;
      R_P1:    req_gnt = 1'b1;
      default: req_gnt = (&req_val) ? prio : req_val[1];
    endcase
    m_req_val        = rst_n & req_val[req_gnt];
    m_req_dat        = req_dat[req_gnt];
    req_rdy          = '0;
    req_rdy[req_gnt] = rst_n & m_req_rdy;
  end

  // ---------------- response split ----------------
  rsp_st_e    rsp_st, rsp_st_nxt;
  logic [7:0] rsp_cnt, rsp_cnt_nxt;
  logic       rsp_sel, rsp_hs;
  logic [7:0] rsp_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_st  <= S_IDLE;
      rsp_cnt <= '0;
    end else begin
      rsp_st  <= rsp_st_nxt;
      rsp_cnt <= rsp_cnt_nxt;
    end
  end

  assign rsp_hs  = m_rsp_val & m_rsp_rdy;
  assign rsp_len = m_rsp_dat[29:22];

  always_comb begin
    rsp_st_nxt  = rsp_st;
    rsp_cnt_nxt = rsp_cnt;
    if (rsp_hs) begin
      if (rsp_st == S_IDLE) begin
        if (rsp_len != 8'd0) begin
          rsp_cnt_nxt = rsp_len;
          rsp_st_nxt  = rsp_sel ? S_P1 : S_P0;
        end
      end else begin
        rsp_cnt_nxt = rsp_cnt - 8'd1;
        if (rsp_cnt == 8'd1) rsp_st_nxt = S_IDLE;
      end
    end
  end

  always_comb begin
    rsp_sel = 1'b0;
    unique case (rsp_st)
      S_P0:    rsp_sel = 1'b0;
      S_P1:    rsp_sel = 1'b1;
      default: rsp_sel = (m_rsp_dat[63:50] == P1_CHIPID);
    endcase
    rsp_val          = '0;
    rsp_val[rsp_sel] = rst_n & m_rsp_val;
    m_rsp_rdy        = rst_n & rsp_rdy[rsp_sel];
  end

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Randomized bench for noc_mem_arbiter: packet-level reference model plus
// per-port stream scoreboards for both the request merge and response split.
module tb_noc_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        s0_req_val = 0, s1_req_val = 0, m_req_rdy = 0;
  logic [63:0] s0_req_dat = '0, s1_req_dat = '0, m_req_dat;
  logic        s0_req_rdy, s1_req_rdy, m_req_val;
  logic        m_rsp_val = 0, s0_rsp_rdy = 0, s1_rsp_rdy = 0;
  logic [63:0] m_rsp_dat = '0, s0_rsp_dat, s1_rsp_dat;
  logic        m_rsp_rdy, s0_rsp_val, s1_rsp_val;

  noc_mem_arbiter #(.DATA_W(64), .P1_CHIPID(14'h2000)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_req_val(s0_req_val), .s0_req_dat(s0_req_dat), .s0_req_rdy(s0_req_rdy),
    .s1_req_val(s1_req_val), .s1_req_dat(s1_req_dat), .s1_req_rdy(s1_req_rdy),
    .m_req_val(m_req_val), .m_req_dat(m_req_dat), .m_req_rdy(m_req_rdy),
    .m_rsp_val(m_rsp_val), .m_rsp_dat(m_rsp_dat), .m_rsp_rdy(m_rsp_rdy),
    .s0_rsp_val(s0_rsp_val), .s0_rsp_dat(s0_rsp_dat), .s0_rsp_rdy(s0_rsp_rdy),
    .s1_rsp_val(s1_rsp_val), .s1_rsp_dat(s1_rsp_dat), .s1_rsp_rdy(s1_rsp_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [63:0] sq [2][$];
  logic [63:0] exp_req [2][$];
  logic [63:0] req_log [$];
  int          hs_cyc [$];
  logic [63:0] mq [$];
  logic [63:0] exp_rsp [2][$];
  logic [63:0] got_rsp [2][$];
  int vpct [2];
  int srdy_pct [2];
  int rdy_mode = 1, mpct = 0;
  logic [1:0] sv = '0, hold = '0;
  logic mhold = 1'b0, tog = 1'b0;
  int r_owner = -1, r_prio = 0, r_left = 0, s_owner = -1, s_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_req(input int p, input int len);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[29:22] = len[7:0];
    d[0] = p[0];
    sq[p].push_back(d); exp_req[p].push_back(d);
    for (int k = 0; k < len; k++) begin
      d = {$urandom, $urandom};
      d[0] = p[0];
      sq[p].push_back(d); exp_req[p].push_back(d);
    end
  endtask

  // Payload chip-ID bits point at the other port to prove routing is locked per packet.
  task automatic load_rsp(input int p, input int len);
    logic [63:0] d;
    d = {$urandom, $urandom};
    if (p == 1) d[63:50] = 14'h2000;
    else if (d[63:50] == 14'h2000) d[63:50] = 14'h0000;
    d[29:22] = len[7:0];
    mq.push_back(d); exp_rsp[p].push_back(d);
    for (int k = 0; k < len; k++) begin
      d = {$urandom, $urandom};
      d[63:50] = (p == 1) ? 14'h0000 : 14'h2000;
      mq.push_back(d); exp_rsp[p].push_back(d);
    end
  endtask

  task automatic cycle();
    int g, t;
    logic mv;
    logic [1:0] sr;
    logic [63:0] md, d;
    @(posedge clk); #1; cyc++;
    for (int p = 0; p < 2; p++)
      if (!hold[p]) sv[p] = (sq[p].size() > 0) && ($urandom_range(1, 100) <= vpct[p]);
    s0_req_val = sv[0];
    s1_req_val = sv[1];
    s0_req_dat = (sq[0].size() > 0) ? sq[0][0] : {$urandom, $urandom};
    s1_req_dat = (sq[1].size() > 0) ? sq[1][0] : {$urandom, $urandom};
    tog = ~tog;
    m_req_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? tog : ($urandom_range(0, 3) != 0);
    mv = mhold || ((mq.size() > 0) && ($urandom_range(1, 100) <= mpct));
    md = (mq.size() > 0) ? mq[0] : 64'h0;
    m_rsp_val = mv;
    m_rsp_dat = md;
    for (int p = 0; p < 2; p++) sr[p] = ($urandom_range(1, 100) <= srdy_pct[p]);
    s0_rsp_rdy = sr[0];
    s1_rsp_rdy = sr[1];
    #3;
    // request side: owner locked mid-packet, else round-robin among valid ports
    if (r_owner >= 0) g = r_owner;
    else if (sv[0] && sv[1]) g = r_prio;
    else g = sv[1] ? 1 : 0;
    chk("m_req_val", m_req_val, sv[g]);
    if (sv[g]) chk("m_req_dat", m_req_dat, sq[g][0]);
    chk("s0_req_rdy", s0_req_rdy, (g == 0) && m_req_rdy);
    chk("s1_req_rdy", s1_req_rdy, (g == 1) && m_req_rdy);
    if (sv[g] && m_req_rdy) begin
      d = sq[g].pop_front();
      req_log.push_back(d); hs_cyc.push_back(cyc);
      if (r_owner < 0) begin
        if (d[29:22] == 8'd0) r_prio = 1 - g;
        else begin r_owner = g; r_left = int'(d[29:22]); end
      end else begin
        r_left--;
        if (r_left == 0) begin r_owner = -1; r_prio = 1 - g; end
      end
    end
    for (int p = 0; p < 2; p++) hold[p] = sv[p] && !(sv[g] && m_req_rdy && g == p);
    // response side
    if (s_owner >= 0) t = s_owner;
    else t = (md[63:50] == 14'h2000) ? 1 : 0;
    chk("s0_rsp_val", s0_rsp_val, mv && t == 0);
    chk("s1_rsp_val", s1_rsp_val, mv && t == 1);
    chk("m_rsp_rdy", m_rsp_rdy, sr[t]);
    if (mv) chk("rsp_dat", (t == 1) ? s1_rsp_dat : s0_rsp_dat, md);
    if (mv && sr[t]) begin
      d = mq.pop_front();
      got_rsp[t].push_back(d);
      if (s_owner < 0) begin
        if (d[29:22] != 8'd0) begin s_owner = t; s_left = int'(d[29:22]); end
      end else begin
        s_left--;
        if (s_left == 0) s_owner = -1;
      end
    end
    mhold = mv && !sr[t];
  endtask

  task automatic clear_all();
    for (int p = 0; p < 2; p++) begin
      sq[p].delete(); exp_req[p].delete(); exp_rsp[p].delete(); got_rsp[p].delete();
    end
    mq.delete(); req_log.delete(); hs_cyc.delete();
    hold = '0; mhold = 1'b0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((sq[0].size() + sq[1].size() + mq.size()) > 0 && n < budget) begin
      cycle(); n++;
    end
    chk("drain_pending", sq[0].size() + sq[1].size() + mq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s0_req_val = 1; s1_req_val = 1; m_req_rdy = 1;
    m_rsp_val = 1; s0_rsp_rdy = 1; s1_rsp_rdy = 1;
    #1;
    chk("rst_m_req_val", m_req_val, 0);
    chk("rst_s0_req_rdy", s0_req_rdy, 0);
    chk("rst_s1_req_rdy", s1_req_rdy, 0);
    chk("rst_m_rsp_rdy", m_rsp_rdy, 0);
    chk("rst_s0_rsp_val", s0_rsp_val, 0);
    chk("rst_s1_rsp_val", s1_rsp_val, 0);
    repeat (2) @(posedge clk);
    #1;
    s0_req_val = 0; s1_req_val = 0; m_req_rdy = 0;
    m_rsp_val = 0; s0_rsp_rdy = 0; s1_rsp_rdy = 0;
    rst_n = 1'b1;
    r_owner = -1; r_prio = 0; s_owner = -1;
    clear_all();
  endtask

  // Splits the merged request log by source tag, checks packets are contiguous,
  // and compares each port's delivered flits with what it sent.
  task automatic check_streams();
    logic [63:0] got [2][$];
    int i, len;
    i = 0;
    while (i < req_log.size()) begin
      len = int'(req_log[i][29:22]);
      for (int j = 1; j <= len; j++)
        if (i + j < req_log.size()) chk("pkt_contig", req_log[i + j][0], req_log[i][0]);
      i = i + len + 1;
    end
    foreach (req_log[k]) got[int'(req_log[k][0])].push_back(req_log[k]);
    for (int p = 0; p < 2; p++) begin
      chk("req_count", got[p].size(), exp_req[p].size());
      for (int k = 0; k < got[p].size() && k < exp_req[p].size(); k++)
        chk("req_flit", got[p][k], exp_req[p][k]);
      chk("rsp_count", got_rsp[p].size(), exp_rsp[p].size());
      for (int k = 0; k < got_rsp[p].size() && k < exp_rsp[p].size(); k++)
        chk("rsp_flit", got_rsp[p][k], exp_rsp[p][k]);
    end
    clear_all();
  endtask

  initial begin
    int n;
    vpct = '{0, 0};
    srdy_pct = '{100, 100};
    do_reset();

    // single port, length 2, no backpressure
    vpct = '{100, 0}; rdy_mode = 1; mpct = 0;
    load_req(0, 2);
    run(50);
    chk("single_flits", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) chk("single_consec", hs_cyc[2] - hs_cyc[0], 2);
    check_streams();

    // contention from reset: strict alternation of length-1 packets
    do_reset();
    vpct = '{100, 100};
    repeat (3) begin load_req(0, 1); load_req(1, 1); end
    run(100);
    for (int k = 0; k < 6; k++)
      if (2 * k < req_log.size()) chk("contend_order", req_log[2 * k][0], k % 2);
    check_streams();

    // toggling backpressure with both ports loaded
    rdy_mode = 2;
    load_req(1, 3); load_req(0, 3);
    run(100);
    check_streams();

    // response routing then a stalled port-0 response
    vpct = '{0, 0}; mpct = 100; srdy_pct = '{100, 100};
    load_rsp(1, 0); load_rsp(0, 2);
    run(50);
    chk("route_s1_cnt", got_rsp[1].size(), 1);
    chk("route_s0_cnt", got_rsp[0].size(), 3);
    check_streams();
    srdy_pct = '{0, 100};
    load_rsp(0, 2);
    repeat (5) cycle();
    srdy_pct = '{100, 100};
    run(50);
    check_streams();

    // randomized mixed traffic, including a maximum-length packet
    do_reset();
    vpct = '{60, 60}; rdy_mode = 0; mpct = 70; srdy_pct = '{70, 70};
    for (int k = 0; k < 30; k++) begin
      load_req(0, $urandom_range(0, 4));
      load_req(1, $urandom_range(0, 4));
      load_rsp($urandom_range(0, 1), $urandom_range(0, 4));
    end
    load_req(0, 255);
    load_rsp(1, 255);
    load_req(1, 2);
    run(20000);
    check_streams();

    // reset mid-packet after prio has moved to port 1
    vpct = '{100, 0}; rdy_mode = 1; mpct = 0; srdy_pct = '{100, 100};
    load_req(0, 0);
    run(20);
    check_streams();
    load_req(0, 4);
    n = 0;
    while (req_log.size() < 2 && n < 50) begin cycle(); n++; end
    chk("partial_flits", req_log.size(), 2);
    do_reset();
    vpct = '{100, 100};
    load_req(1, 0); load_req(0, 2);
    run(50);
    chk("post_rst_cnt", req_log.size(), 4);
    if (req_log.size() > 0) chk("post_rst_first", req_log[0][0], 0);
    check_streams();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
